finv_table_loader: RTL and testbench



---
 rtl/finv_pkg.sv | 22 ++
 rtl/finv_seq_div.sv | 78 +++++++
 rtl/finv_table_loader.sv | 171 +++++++++++++++++
 tb/tb_finv_table_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/finv_pkg.sv
// Shared constants and state type for the reciprocal seed-table loader.
package finv_pkg;

   localparam int unsigned FINV_ADDR_W         = 10;
   localparam int unsigned FINV_DATA_W         = 24;
   localparam int unsigned FINV_Q_W            = 25;
   localparam int unsigned FINV_DIVIDEND_SHIFT = 34;

   // Divisor n = 1024+k spans 1024..2048, so divisor and remainder share 12 bits.
   localparam int unsigned FINV_REM_W  = 12;
   localparam int unsigned FINV_N_BASE = 1024;
   localparam int unsigned FINV_CNT_W  = 5;

   typedef enum logic [2:0] {
      IDLE,
      DIV0,
      DIV,
      WRITE,
      FIN
   } finv_ld_state_t;

endpackage

// File: rtl/finv_seq_div.sv
// Iterative restoring divider computing floor(2^34 / divisor), one quotient
// bit per cycle from bit 24 down to bit 0.
// The bit-24 step is taken on the start edge; done is high in the 25th cycle
// after start, with q already final during that cycle.
module finv_seq_div
   import finv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [FINV_REM_W-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic [FINV_Q_W-1:0]   q
);

   // Dividend bits above the quotient MSB form the initial partial remainder;
   // every lower dividend bit is zero, so each step shifts in a zero.
   localparam logic [FINV_REM_W-1:0] REM_INIT   = FINV_REM_W'(1 << (FINV_DIVIDEND_SHIFT - FINV_Q_W));
   localparam logic [FINV_CNT_W-1:0] STEPS_LEFT = FINV_CNT_W'(FINV_Q_W - 2);

   logic [FINV_REM_W-1:0] rem;
   logic [FINV_REM_W-1:0] den;
   logic [FINV_CNT_W-1:0] cnt;

   logic [FINV_REM_W-1:0] rem_src;
   logic [FINV_REM_W-1:0] den_src;
   logic [FINV_REM_W:0]   shifted;
   logic [FINV_REM_W:0]   diff;
   logic                  q_bit;
   logic [FINV_REM_W-1:0] rem_step;

   // One restoring step; when idle it operates on the fresh operands so the
   // first quotient bit is resolved on the start edge.
   always_comb begin
      rem_src = rem;
      den_src = den;
      if (!busy) begin
         rem_src = REM_INIT;
         den_src = divisor;
      end
      shifted  = {rem_src, 1'b0};
      diff     = shifted - {1'b0, den_src};
      q_bit    = (shifted >= {1'b0, den_src});
      rem_step = q_bit ? FINV_REM_W'(diff) : FINV_REM_W'(shifted);
   end

   // Operand capture, remainder/quotient shifting and step counting.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy <= 1'b0;
         done <= 1'b0;
         rem  <= '0;
         den  <= '0;
         cnt  <= '0;
         q    <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            busy <= 1'b1;
            den  <= divisor;
            rem  <= rem_step;
            q    <= FINV_Q_W'(q_bit);
            cnt  <= STEPS_LEFT;
         end else if (busy) begin
            rem <= rem_step;
            q   <= {q[FINV_Q_W-2:0], q_bit};
            if (cnt == '0) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/finv_table_loader.sv
// Builds the reciprocal seed table in hardware: for every index i it computes
// b[i] = (q(i)+q(i+1))>>1 and a[i] = (b*b)>>24 with q(k) = floor(2^34/(1024+k)),
// then writes the pair through the RAM load/addr/in_a/in_b port.
// Optional macro FINV_LOADER_CKSUM_EN adds a 32-bit running sum of in_a+in_b.
module finv_table_loader
   import finv_pkg::*;
#(
   parameter int unsigned ADDR_W = FINV_ADDR_W,
   parameter int unsigned DATA_W = FINV_DATA_W
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              load,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] in_a,
   output logic [DATA_W-1:0] in_b
`ifdef FINV_LOADER_CKSUM_EN
   ,
   output logic [31:0]       cksum
`endif
);

   // Index carries one spare bit so the terminal compare never relies on wrap.
   localparam int unsigned       IDX_W    = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << ADDR_W) - 1);

   finv_ld_state_t state;
   finv_ld_state_t state_next;

   logic [IDX_W-1:0]      idx;
   logic [FINV_Q_W-1:0]   q_prev;

   logic                  div_go;
   logic                  div_start;
   logic [IDX_W-1:0]      div_k;
   logic [FINV_REM_W-1:0] div_n;
   logic                  div_busy;
   logic                  div_done;
   logic [FINV_Q_W-1:0]   div_q;

   logic [FINV_Q_W:0]     q_sum;
   logic [DATA_W-1:0]     b_next;
   logic [2*DATA_W-1:0]   prod;
   logic [DATA_W-1:0]     a_next;

   finv_seq_div u_div (
      .clk     (clk),
      .rstn    (rstn),
      .start   (div_start),
      .divisor (div_n),
      .busy    (div_busy),
      .done    (div_done),
      .q       (div_q)
   );

   // Next state, divider launch and status/strobe decode.
   always_comb begin
      state_next = state;
      div_go     = 1'b0;
      div_k      = '0;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DIV0;
               div_go     = 1'b1;
            end
         end
         DIV0: begin
            busy = 1'b1;
            if (div_done) begin
               state_next = DIV;
               div_go     = 1'b1;
               div_k      = idx + IDX_W'(1);
            end
         end
         DIV: begin
            busy = 1'b1;
            if (div_done) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            busy = 1'b1;
            load = 1'b1;
            if (idx == LAST_IDX) begin
               state_next = FIN;
            end else begin
               // Next DIV serves index i+1, which needs q(i+2).
               state_next = DIV;
               div_go     = 1'b1;
               div_k      = idx + IDX_W'(2);
            end
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      div_start = div_go & ~div_busy;
      div_n     = FINV_REM_W'(FINV_N_BASE) + FINV_REM_W'(div_k);
   end

   // Coefficient formation from the held and freshly computed quotients.
   always_comb begin
      q_sum  = {1'b0, q_prev} + {1'b0, div_q};
      b_next = DATA_W'(q_sum >> 1);
      prod   = b_next * b_next;
      a_next = DATA_W'(prod >> DATA_W);
   end

   // State register, index, quotient history and registered RAM write data.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state  <= IDLE;
         idx    <= '0;
         q_prev <= '0;
         addr   <= '0;
         in_a   <= '0;
         in_b   <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  idx <= '0;
               end
            end
            DIV0: begin
               if (div_done) begin
                  q_prev <= div_q;
               end
            end
            DIV: begin
               if (div_done) begin
                  q_prev <= div_q;
                  in_b   <= b_next;
                  in_a   <= a_next;
                  addr   <= idx[ADDR_W-1:0];
               end
            end
            WRITE: begin
               if (idx != LAST_IDX) begin
                  idx <= idx + IDX_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FINV_LOADER_CKSUM_EN
   // Running modulo-2^32 sum of every written coefficient pair.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cksum <= '0;
      end else if (state == IDLE && start) begin
         cksum <= '0;
      end else if (state == WRITE) begin
         cksum <= cksum + 32'(in_a) + 32'(in_b);
      end
   end
`endif

endmodule

// File: tb/tb_finv_table_loader.sv
// Self-checking bench for finv_table_loader: randomized spurious starts and
// idle gaps, scoreboard against an arithmetic reference table.
module tb_finv_table_loader;

   localparam int unsigned ENTRIES = 1024;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        busy;
   logic        done;
   logic        load;
   logic [9:0]  addr;
   logic [23:0] in_a;
   logic [23:0] in_b;
`ifdef FINV_LOADER_CKSUM_EN
   logic [31:0] cksum;
`endif

   int unsigned     n_vec = 0;
   int unsigned     n_err = 0;
   longint unsigned cyc   = 0;

   longint unsigned ma [ENTRIES];
   longint unsigned mb [ENTRIES];
   longint unsigned model_sum;

   longint unsigned s_cyc         = 0;
   longint unsigned last_load_cyc = 0;
   longint unsigned done_cyc      = 0;
   int unsigned     exp_idx       = 0;
   int unsigned     done_cnt      = 0;

   finv_table_loader #(.ADDR_W(10), .DATA_W(24)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .busy  (busy),
      .done  (done),
      .load  (load),
      .addr  (addr),
      .in_a  (in_a),
      .in_b  (in_b)
`ifdef FINV_LOADER_CKSUM_EN
      ,
      .cksum (cksum)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference table straight from the defining formulas.
   task automatic build_model();
      longint unsigned q [ENTRIES+1];
      longint unsigned b;
      longint unsigned a;
      model_sum = 0;
      for (int k = 0; k <= ENTRIES; k++)
         q[k] = (64'd1 << 34) / longint'(1024 + k);
      for (int i = 0; i < ENTRIES; i++) begin
         b     = (q[i] + q[i+1]) / 2;
         a     = (b * b) / (64'd1 << 24);
         mb[i] = b;
         ma[i] = a;
         model_sum = (model_sum + a + b) % (64'd1 << 32);
      end
   endtask

   // Scoreboard on every load strobe; also timestamps done.
   always @(negedge clk) begin
      if (rstn === 1'b1 && load === 1'b1) begin
         if (exp_idx >= ENTRIES) begin
            check("load_overrun_idx", exp_idx, ENTRIES - 1);
         end else begin
            check("addr", addr, exp_idx);
            check("in_a", in_a, ma[exp_idx]);
            check("in_b", in_b, mb[exp_idx]);
            if (exp_idx == 0) begin
               check("first_load_latency", cyc - s_cyc, 51);
               check("first_in_b", in_b, 24'hFFE007);
               check("first_in_a", in_a, 24'hFFC011);
            end else begin
               check("load_spacing", cyc - last_load_cyc, 26);
            end
            if (exp_idx == ENTRIES - 1) begin
               check("last_in_b", in_b, 24'h800801);
               check("last_in_a", in_a, 24'h400801);
            end
         end
         last_load_cyc = cyc;
         exp_idx++;
      end
      if (rstn === 1'b1 && done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic pulse_start();
      @(posedge clk);
      #1;
      start    = 1'b1;
      s_cyc    = cyc;
      exp_idx  = 0;
      done_cnt = 0;
      done_cyc = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_build(input bit spurious);
      longint unsigned rel;
      longint unsigned r;
      r = longint'($urandom_range(200, 26000));
      pulse_start();
      for (int t = 0; t < 27000 && done_cnt == 0; t++) begin
         @(posedge clk);
         #1;
         rel   = cyc - s_cyc;
         start = spurious && (rel == 100 || rel == 5000 || rel == r);
      end
      start = 1'b0;
      check("done_seen", done_cnt, 1);
      repeat (5) @(posedge clk);
      #1;
      check("done_pulses", done_cnt, 1);
      check("done_latency", done_cyc - s_cyc, 26650);
      check("load_count", exp_idx, ENTRIES);
      check("busy_after_done", busy, 0);
      check("load_after_done", load, 0);
   endtask

   initial begin
      build_model();
      rstn  = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_load", load, 0);
      check("rst_addr", addr, 0);
      check("rst_in_a", in_a, 0);
      check("rst_in_b", in_b, 0);
`ifdef FINV_LOADER_CKSUM_EN
      check("rst_cksum", cksum, 0);
`endif

      // start coinciding with reset must not launch a build
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rstn  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("start_in_reset_busy", busy, 0);

      repeat ($urandom_range(1, 20)) @(posedge clk);
      run_build(1'b1);
`ifdef FINV_LOADER_CKSUM_EN
      check("cksum_build1", cksum, model_sum);
`endif

      // abort mid-build with a one-cycle reset
      repeat ($urandom_range(1, 20)) @(posedge clk);
      pulse_start();
      for (int t = 0; t < 3000 && (cyc - s_cyc) < 3000; t++) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      check("abort_load", load, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_addr", addr, 0);

      repeat ($urandom_range(1, 20)) @(posedge clk);
      run_build(1'b1);
`ifdef FINV_LOADER_CKSUM_EN
      check("cksum_build2", cksum, model_sum);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
